// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller beside the ID stage of the MIPS pipeline.
// Latency: fwd/stall/bubble/stall_cnt/RUN flush are combinational; scoreboard and FSM update on clk.
// Backpressure: asserts stall (hold PC and IF/ID) and bubble (NOP into ID/EX) on load-use hazards.
//
// Ports:
//   clk, reset_n          core clock, asynchronous active-low reset
//   id_valid .. id_ctrl_taken   decoded ID-stage instruction fields
//   fwd_a, fwd_b          operand source: 0 = register file, k+1 = scoreboard entry k
//   stall, bubble, flush  pipeline control
//   state                 0 = RUN, 1 = LSTALL, 2 = FLUSH
//   stall_cnt             remaining load-stall cycles including the current one
module pipe_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter int FWD_DEPTH    = 2,
    parameter int LOAD_LAT     = 1,
    parameter int CTRL_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_is_load,
    input  logic              id_ctrl_taken,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        state,
    output logic [2:0]        stall_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [2:0] LOAD_LAT_3 = 3'(LOAD_LAT);
    localparam logic [2:0] CTRL_BUB_3 = 3'(CTRL_BUBBLES);

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } sb_entry_t;

    // sb[0] is the instruction now in EX, sb[1] in MEM, and so on.
    sb_entry_t  sb [FWD_DEPTH];

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    logic       hit_a, hit_b;
    logic       ld_a, ld_b;
    logic [2:0] k_a, k_b;
    logic       lh_a, lh_b;
    logic       hazard;
    logic [2:0] k_min;
    logic [2:0] run_cnt;
    logic       issue;

    logic [2:0] fwd_a_c, fwd_b_c;
    logic       stall_c, bubble_c, flush_c;
    logic [2:0] stall_cnt_c;

    function automatic logic src_match(input logic              use_s,
                                       input logic [REG_AW-1:0] s,
                                       input sb_entry_t         e);
        return use_s && (s != '0) && e.valid && e.wreg && (e.dest == s);
    endfunction

    // Scan from the oldest entry down so the youngest (lowest k) match wins.
    always_comb begin
        hit_a = 1'b0;
        ld_a  = 1'b0;
        k_a   = 3'd0;
        hit_b = 1'b0;
        ld_b  = 1'b0;
        k_b   = 3'd0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (src_match(id_use_rs, id_rs, sb[k])) begin
                hit_a = 1'b1;
                ld_a  = sb[k].is_load;
                k_a   = 3'(k);
            end
            if (src_match(id_use_rt, id_rt, sb[k])) begin
                hit_b = 1'b1;
                ld_b  = sb[k].is_load;
                k_b   = 3'(k);
            end
        end
    end

    // Load data is not yet available in entries younger than LOAD_LAT.
    assign lh_a = hit_a && ld_a && (k_a < LOAD_LAT_3);
    assign lh_b = hit_b && ld_b && (k_b < LOAD_LAT_3);

    assign fwd_a_c = (hit_a && !lh_a) ? (k_a + 3'd1) : 3'd0;
    assign fwd_b_c = (hit_b && !lh_b) ? (k_b + 3'd1) : 3'd0;

    // The youngest hazarding producer sets the stall length.
    always_comb begin
        k_min = 3'd0;
        if (lh_a && lh_b) begin
            k_min = (k_a < k_b) ? k_a : k_b;
        end else if (lh_a) begin
            k_min = k_a;
        end else if (lh_b) begin
            k_min = k_b;
        end
    end

    assign hazard  = id_valid && (lh_a || lh_b);
    assign run_cnt = LOAD_LAT_3 - k_min;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        stall_cnt_c = 3'd0;
        case (state_q)
            ST_RUN: begin
                // Hazard outranks a taken transfer: the branch must see fresh operands first.
                if (hazard) begin
                    stall_c     = 1'b1;
                    bubble_c    = 1'b1;
                    stall_cnt_c = run_cnt;
                    if (run_cnt != 3'd1) begin
                        state_d = ST_LSTALL;
                        cnt_d   = run_cnt - 3'd1;
                    end
                end else if (id_valid && id_ctrl_taken) begin
                    flush_c = 1'b1;
                    if (CTRL_BUB_3 != 3'd1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CTRL_BUB_3 - 3'd1;
                    end
                end
            end
            ST_LSTALL: begin
                stall_c     = 1'b1;
                bubble_c    = 1'b1;
                stall_cnt_c = cnt_q;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // During FLUSH the ID contents are being killed, so nothing is issued.
    assign issue = id_valid && !stall_c && (state_q != ST_FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                sb[0] <= '{valid: 1'b1, wreg: id_wreg, dest: id_dest, is_load: id_is_load};
            end else begin
                sb[0] <= '0;
            end
            for (int k = 1; k < FWD_DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // Combinational outputs are forced quiet while reset is held, whatever ID presents.
    assign fwd_a     = reset_n ? fwd_a_c     : 3'd0;
    assign fwd_b     = reset_n ? fwd_b_c     : 3'd0;
    assign stall     = reset_n ? stall_c     : 1'b0;
    assign bubble    = reset_n ? bubble_c    : 1'b0;
    assign flush     = reset_n ? flush_c     : 1'b0;
    assign stall_cnt = reset_n ? stall_cnt_c : 3'd0;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (default parameters, and FWD_DEPTH=4/LOAD_LAT=3/
// CTRL_BUBBLES=3) with independent ID stimulus, checked every cycle against an issue-history model,
// plus literal expectations at key points of each directed scenario.
module tb_pipe_hazard_unit;

    logic       clk;
    logic       reset_n;

    logic       id_valid      [2];
    logic [4:0] id_rs         [2];
    logic [4:0] id_rt         [2];
    logic       id_use_rs     [2];
    logic       id_use_rt     [2];
    logic       id_wreg       [2];
    logic [4:0] id_dest       [2];
    logic       id_is_load    [2];
    logic       id_ctrl_taken [2];

    logic [2:0] fwd_a     [2];
    logic [2:0] fwd_b     [2];
    logic       stall     [2];
    logic       bubble    [2];
    logic       flush     [2];
    logic [1:0] state     [2];
    logic [2:0] stall_cnt [2];

    int checks   = 0;
    int failures = 0;

    pipe_hazard_unit u_def (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
        .id_use_rs(id_use_rs[0]), .id_use_rt(id_use_rt[0]), .id_wreg(id_wreg[0]),
        .id_dest(id_dest[0]), .id_is_load(id_is_load[0]), .id_ctrl_taken(id_ctrl_taken[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall(stall[0]), .bubble(bubble[0]),
        .flush(flush[0]), .state(state[0]), .stall_cnt(stall_cnt[0])
    );

    pipe_hazard_unit #(.REG_AW(5), .FWD_DEPTH(4), .LOAD_LAT(3), .CTRL_BUBBLES(3)) u_big (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
        .id_use_rs(id_use_rs[1]), .id_use_rt(id_use_rt[1]), .id_wreg(id_wreg[1]),
        .id_dest(id_dest[1]), .id_is_load(id_is_load[1]), .id_ctrl_taken(id_ctrl_taken[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall(stall[1]), .bubble(bubble[1]),
        .flush(flush[1]), .state(state[1]), .stall_cnt(stall_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_fd(input int i); return (i == 0) ? 2 : 4; endfunction
    function automatic int p_ll(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int p_cb(input int i); return (i == 0) ? 1 : 3; endfunction

    // ---------------- model: history of what was issued in each cycle ----------------
    bit       rec_v [2][1024];
    bit       rec_w [2][1024];
    bit [4:0] rec_d [2][1024];
    bit       rec_l [2][1024];
    int       ls_start [2];
    int       ls_end   [2];
    int       fl_start [2];
    int       fl_end   [2];
    int       cyc;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // The producer k stages ahead was issued k+1 cycles ago.
    function automatic int winner(input int i, input bit u, input bit [4:0] s, input int c);
        for (int k = 0; k < p_fd(i); k++) begin
            int idx;
            idx = c - 1 - k;
            if (idx >= 0 && u && s != 0 && rec_v[i][idx] && rec_w[i][idx] && rec_d[i][idx] == s)
                return k;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 1024; j++) rec_v[i][j] = 1'b0;
            ls_start[i] = -1; ls_end[i] = -1;
            fl_start[i] = -1; fl_end[i] = -1;
        end
        cyc = 0;
    endtask

    task automatic model_step(input int i);
        int c, ka, kb, kmin, n;
        bit lha, lhb, issue;
        int efa, efb, est, efl, esta, esc;
        string p;
        c  = cyc;
        p  = $sformatf("u%0d.", i);
        ka = winner(i, id_use_rs[i], id_rs[i], c);
        kb = winner(i, id_use_rt[i], id_rt[i], c);
        lha = (ka >= 0) && rec_l[i][c-1-ka] && (ka < p_ll(i));
        lhb = (kb >= 0) && rec_l[i][c-1-kb] && (kb < p_ll(i));
        efa = (ka >= 0 && !lha) ? ka + 1 : 0;
        efb = (kb >= 0 && !lhb) ? kb + 1 : 0;
        est = 0; efl = 0; esta = 0; esc = 0; issue = 0;
        if (c > fl_start[i] && c <= fl_end[i]) begin
            esta = 2; efl = 1;
        end else if (c > ls_start[i] && c <= ls_end[i]) begin
            esta = 1; est = 1; esc = ls_end[i] - c + 1;
        end else if (id_valid[i] && (lha || lhb)) begin
            kmin = (lha && lhb) ? ((ka < kb) ? ka : kb) : (lha ? ka : kb);
            n = p_ll(i) - kmin;
            est = 1; esc = n;
            ls_start[i] = c; ls_end[i] = c + n - 1;
        end else begin
            issue = id_valid[i];
            if (id_valid[i] && id_ctrl_taken[i]) begin
                efl = 1;
                fl_start[i] = c; fl_end[i] = c + p_cb(i) - 1;
            end
        end
        rec_v[i][c] = issue;
        rec_w[i][c] = id_wreg[i];
        rec_d[i][c] = id_dest[i];
        rec_l[i][c] = id_is_load[i];
        chk({p, "fwd_a"},     int'(fwd_a[i]),     efa);
        chk({p, "fwd_b"},     int'(fwd_b[i]),     efb);
        chk({p, "stall"},     int'(stall[i]),     est);
        chk({p, "bubble"},    int'(bubble[i]),    est);
        chk({p, "flush"},     int'(flush[i]),     efl);
        chk({p, "state"},     int'(state[i]),     esta);
        chk({p, "stall_cnt"}, int'(stall_cnt[i]), esc);
    endtask

    // Compare process: every falling edge, outputs against the model (or zero in reset).
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.rst_outputs", i),
                        int'({fwd_a[i], fwd_b[i], stall[i], bubble[i], flush[i], state[i], stall_cnt[i]}), 0);
                end
                model_clear();
            end else if (cyc < 1023) begin
                for (int i = 0; i < 2; i++) model_step(i);
                cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input int i, input bit v, input bit [4:0] rs, input bit urs,
                       input bit [4:0] rt, input bit urt, input bit w, input bit [4:0] d,
                       input bit ld, input bit tk);
        id_valid[i] = v;   id_rs[i] = rs;     id_use_rs[i] = urs;
        id_rt[i] = rt;     id_use_rt[i] = urt; id_wreg[i] = w;
        id_dest[i] = d;    id_is_load[i] = ld; id_ctrl_taken[i] = tk;
        #1;
    endtask

    task automatic idle(input int i);
        drv(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle(0);
        idle(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state[1]), 0);
        chk("rst_stall", int'(stall[1]), 0);
        reset_n = 1'b1;
        #1;

        // Forwarding on the default instance: ADD r3; ADD r4,r3,r3; SUB r5,r3,r0; consumer r3.
        drv(0, 1, 1, 1, 2, 1, 1, 3, 0, 0);  chk("A.first_fwd_a", int'(fwd_a[0]), 0);  nxt();
        drv(0, 1, 3, 1, 3, 1, 1, 4, 0, 0);  chk("A.ex_fwd_a", int'(fwd_a[0]), 1);
                                           chk("A.ex_fwd_b", int'(fwd_b[0]), 1);     nxt();
        drv(0, 1, 3, 1, 0, 1, 1, 5, 0, 0);  chk("A.mem_fwd_a", int'(fwd_a[0]), 2);
                                           chk("A.r0_fwd_b", int'(fwd_b[0]), 0);     nxt();
        drv(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);  chk("A.gone_fwd_a", int'(fwd_a[0]), 0);  nxt();

        // Load-use with LOAD_LAT=1: LW r5 then ADD r6,r5,r0.
        drv(0, 1, 1, 1, 0, 0, 1, 5, 1, 0);  nxt();
        drv(0, 1, 5, 1, 0, 1, 1, 6, 0, 0);
        chk("B.stall", int'(stall[0]), 1);
        chk("B.bubble", int'(bubble[0]), 1);
        chk("B.stall_cnt", int'(stall_cnt[0]), 1);
        chk("B.state_run", int'(state[0]), 0);                                      nxt();
        chk("B.released", int'(stall[0]), 0);
        chk("B.fwd_mem", int'(fwd_a[0]), 2);                                        nxt();

        // Two writers of r9: youngest wins. r0 writers never match.
        drv(0, 1, 0, 0, 0, 0, 1, 9, 0, 0);  nxt();
        drv(0, 1, 0, 0, 0, 0, 1, 9, 0, 0);  nxt();
        drv(0, 1, 9, 1, 0, 0, 0, 0, 0, 0);  chk("E.youngest", int'(fwd_a[0]), 1);   nxt();
        drv(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);  nxt();
        drv(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);  chk("E.r0_fwd_a", int'(fwd_a[0]), 0);
                                           chk("E.r0_stall", int'(stall[0]), 0);    nxt();
        drv(0, 1, 0, 0, 0, 0, 1, 0, 1, 0);  nxt();
        drv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);  chk("E.r0_load_stall", int'(stall[0]), 0); nxt();
        idle(0);

        // LOAD_LAT=3: LW r7 then consumer -> 3 stall cycles, 2 in LSTALL, then forward from entry 3.
        drv(1, 1, 0, 0, 0, 0, 1, 7, 1, 0);  nxt();
        drv(1, 1, 7, 1, 0, 0, 1, 11, 0, 0);
        chk("C.cnt3", int'(stall_cnt[1]), 3);
        chk("C.stall1", int'(stall[1]), 1);
        chk("C.state_run", int'(state[1]), 0);                                      nxt();
        chk("C.lstall2", int'(state[1]), 1);
        chk("C.cnt2", int'(stall_cnt[1]), 2);                                       nxt();
        chk("C.cnt1", int'(stall_cnt[1]), 1);
        chk("C.stall3", int'(stall[1]), 1);                                         nxt();
        chk("C.done", int'(stall[1]), 0);
        chk("C.fwd4", int'(fwd_a[1]), 4);
        chk("C.back_run", int'(state[1]), 0);                                       nxt();

        // CTRL_BUBBLES=3: taken BEQ -> flush 3 cycles, FLUSH state for 2.
        drv(1, 1, 1, 1, 2, 1, 0, 0, 0, 1);  chk("D.flush0", int'(flush[1]), 1);
                                           chk("D.state0", int'(state[1]), 0);     nxt();
        idle(1);                            chk("D.flush1", int'(flush[1]), 1);
                                           chk("D.state1", int'(state[1]), 2);     nxt();
        chk("D.flush2", int'(flush[1]), 1);                                         nxt();
        chk("D.flush_end", int'(flush[1]), 0);
        chk("D.state_end", int'(state[1]), 0);

        // Taken BEQ whose rs comes from a load in EX: stall first, then the flush run.
        drv(1, 1, 0, 0, 0, 0, 1, 8, 1, 0);  nxt();
        drv(1, 1, 8, 1, 0, 1, 0, 0, 0, 1);  chk("D.hz_stall", int'(stall[1]), 1);
                                           chk("D.hz_noflush", int'(flush[1]), 0); nxt();
        chk("D.hz_lstall", int'(state[1]), 1);                                      nxt();
        chk("D.hz_noflush2", int'(flush[1]), 0);                                    nxt();
        chk("D.br_flush", int'(flush[1]), 1);
        chk("D.br_fwd", int'(fwd_a[1]), 4);
        chk("D.br_nostall", int'(stall[1]), 0);                                     nxt();
        idle(1);                            chk("D.br_state", int'(state[1]), 2);    nxt();
        nxt();
        nxt();

        // Reset in the middle of a load stall.
        drv(1, 1, 0, 0, 0, 0, 1, 10, 1, 0); nxt();
        drv(1, 1, 10, 1, 0, 0, 0, 0, 0, 0); nxt();
        chk("F.in_lstall", int'(state[1]), 1);
        reset_n = 1'b0;
        #1;
        chk("F.rst_state", int'(state[1]), 0);
        chk("F.rst_stall", int'(stall[1]), 0);
        chk("F.rst_cnt", int'(stall_cnt[1]), 0);
        nxt();
        nxt();
        reset_n = 1'b1;
        #1;
        chk("F.post_fwd", int'(fwd_a[1]), 0);
        chk("F.post_stall", int'(stall[1]), 0);
        nxt();
        idle(1);
        nxt();
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
